// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: response-owner encoding and starvation counter width for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DR, OWN_DW} owner_e;
  localparam int STARVE_W = 4;
endpackage

// File: rtl/mem_arb_starve_cnt.sv
// mem_arb_starve_cnt: saturating count of consecutive blocked fetch cycles
//   clk, rst_n    clock, async active-low reset
//   if_req        fetch request
//   if_gnt        fetch grant
//   if_prio_o     fetch has waited long enough to win the next contention
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_gnt,
  output logic if_prio_o
);
  logic [STARVE_W-1:0] starve_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_q <= '0;
    else if (!if_req || if_gnt) starve_q <= '0;
    else if (starve_q != '1) starve_q <= starve_q + 1'b1;
  assign if_prio_o = starve_q >= STARVE_W'(STARVE_LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory arbiter between instruction fetch and data load/store
//   clk, rst_n                                  clock, async active-low reset
//   if_req_i, if_addr_i                         fetch request
//   if_gnt_o, if_rvalid_o, if_rdata_o           fetch grant and registered response
//   d_req_i, d_we_i, d_addr_i, d_wdata_i        data request
//   d_gnt_o, d_rvalid_o, d_rdata_o              data grant and registered response
//   mem_addr_o, mem_data_o, mem_read_en_o,
//   mem_write_en_o, mem_data_i                  memory port (read data combinational)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);
  owner_e            own_q, own_d;
  logic              if_prio;
  logic [DWIDTH-1:0] if_rdata_q, d_rdata_q;
  mem_arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req_i),
    .if_gnt    (if_gnt_o),
    .if_prio_o (if_prio)
  );
  // grants are gated by rst_n so nothing reaches the memory while reset is held
  always_comb begin
    if_gnt_o       = rst_n && if_req_i && (!d_req_i || if_prio);
    d_gnt_o        = rst_n && d_req_i && !if_gnt_o;
    mem_addr_o     = if_gnt_o ? if_addr_i : d_gnt_o ? d_addr_i : '0;
    mem_data_o     = (if_gnt_o || d_gnt_o) ? d_wdata_i : '0;
    mem_read_en_o  = if_gnt_o || (d_gnt_o && !d_we_i);
    mem_write_en_o = d_gnt_o && d_we_i;
    own_d          = if_gnt_o ? OWN_IF : !d_gnt_o ? OWN_NONE : d_we_i ? OWN_DW : OWN_DR;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      own_q      <= OWN_NONE;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      own_q <= own_d;
      if (if_gnt_o) if_rdata_q <= mem_data_i;
      if (d_gnt_o) d_rdata_q <= d_we_i ? '0 : mem_data_i;
    end
  assign if_rvalid_o = own_q == OWN_IF;
  assign d_rvalid_o  = own_q == OWN_DR || own_q == OWN_DW;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven and sequence checks of mem_port_arbiter against a word memory model
module tb_mem_port_arbiter;
  localparam logic [31:0] B = 32'h0100_0000;
  localparam logic [31:0] Z = 32'h0;
  localparam logic T = 1'b1, F = 1'b0;
  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
    logic eig; logic edg;
    logic eiv; logic [31:0] eid;
    logic edv; logic [31:0] edd;
    logic [31:0] ema; logic ere; logic ewe;
  } vec_t;
  logic clk, rst_n;
  logic if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid, mem_re, mem_we;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  logic inr;
  int n_chk = 0, n_fail = 0;
  vec_t v [12];
  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_read_en_o(mem_re), .mem_write_en_o(mem_we),
    .mem_data_i(mem_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign inr = mem_addr >= B && mem_addr < B + 32'd256;
  assign mem_rdata = inr ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;
  always @(posedge clk) if (mem_we && inr) mem[mem_addr[7:2]] <= mem_wdata;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask
  task automatic idle_chk_reset(input string tag);
    chk({tag, " if_gnt"}, 32'(if_gnt), 0);
    chk({tag, " d_gnt"}, 32'(d_gnt), 0);
    chk({tag, " if_rvalid"}, 32'(if_rvalid), 0);
    chk({tag, " d_rvalid"}, 32'(d_rvalid), 0);
    chk({tag, " mem_re"}, 32'(mem_re), 0);
    chk({tag, " mem_we"}, 32'(mem_we), 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " d_rdata"}, d_rdata, 0);
  endtask
  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h1234_5678;
    v[0]  = '{T, B,         F, F, Z,          Z,            T, F, F, Z,            F, Z,            B,          T, F};
    v[1]  = '{F, Z,         F, F, Z,          Z,            F, F, T, 32'h00500093, F, Z,            Z,          F, F};
    v[2]  = '{F, Z,         T, T, B + 32'h10, 32'hCAFEF00D, F, T, F, Z,            F, Z,            B + 32'h10, F, T};
    v[3]  = '{F, Z,         T, F, B + 32'h10, Z,            F, T, F, Z,            T, Z,            B + 32'h10, T, F};
    v[4]  = '{F, Z,         F, F, Z,          Z,            F, F, F, Z,            T, 32'hCAFEF00D, Z,          F, F};
    v[5]  = '{T, Z,         F, F, Z,          Z,            T, F, F, Z,            F, Z,            Z,          T, F};
    v[6]  = '{F, Z,         F, F, Z,          Z,            F, F, T, 32'hDEADBEEF, F, Z,            Z,          F, F};
    v[7]  = '{F, Z,         T, T, B + 32'h20, 32'hA5A5A5A5, F, T, F, Z,            F, Z,            B + 32'h20, F, T};
    v[8]  = '{T, B + 32'h20, F, F, Z,         Z,            T, F, F, Z,            T, Z,            B + 32'h20, T, F};
    v[9]  = '{F, Z,         F, F, Z,          Z,            F, F, T, 32'hA5A5A5A5, F, Z,            Z,          F, F};
    v[10] = '{T, B,         T, F, B + 32'h4,  Z,            F, T, F, Z,            F, Z,            B + 32'h4,  T, F};
    v[11] = '{F, Z,         F, F, Z,          Z,            F, F, F, Z,            T, 32'h12345678, Z,          F, F};
    rst_n = 1'b0;
    drive(T, B, T, F, B + 32'h4, Z);
    repeat (2) @(negedge clk);
    #1 idle_chk_reset("reset");
    @(negedge clk);
    drive(F, Z, F, F, Z, Z);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(v[i].ir, v[i].ia, v[i].dr, v[i].dw, v[i].da, v[i].dd);
      #1;
      chk($sformatf("r%0d if_gnt", i), 32'(if_gnt), 32'(v[i].eig));
      chk($sformatf("r%0d d_gnt", i), 32'(d_gnt), 32'(v[i].edg));
      chk($sformatf("r%0d if_rvalid", i), 32'(if_rvalid), 32'(v[i].eiv));
      chk($sformatf("r%0d d_rvalid", i), 32'(d_rvalid), 32'(v[i].edv));
      chk($sformatf("r%0d mem_addr", i), mem_addr, v[i].ema);
      chk($sformatf("r%0d mem_re", i), 32'(mem_re), 32'(v[i].ere));
      chk($sformatf("r%0d mem_we", i), 32'(mem_we), 32'(v[i].ewe));
      chk($sformatf("r%0d mem_data", i), mem_wdata, (v[i].eig || v[i].edg) ? v[i].dd : Z);
      if (v[i].eiv) chk($sformatf("r%0d if_rdata", i), if_rdata, v[i].eid);
      if (v[i].edv) chk($sformatf("r%0d d_rdata", i), d_rdata, v[i].edd);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(T, B, T, F, B + 32'h4, Z);
      #1;
      chk($sformatf("starve c%0d if_gnt", i), 32'(if_gnt), 32'(i % 5 == 4));
      chk($sformatf("starve c%0d d_gnt", i), 32'(d_gnt), 32'(i % 5 != 4));
      chk($sformatf("starve c%0d if_rvalid", i), 32'(if_rvalid), 32'(i > 0 && (i - 1) % 5 == 4));
      chk($sformatf("starve c%0d d_rvalid", i), 32'(d_rvalid), 32'(i > 0 && (i - 1) % 5 != 4));
    end
    @(negedge clk);
    drive(F, Z, F, F, Z, Z);
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      drive(j != 3, B, T, F, B + 32'h4, Z);
      #1;
      chk($sformatf("withdraw c%0d if_gnt", j), 32'(if_gnt), 32'(j == 8));
      chk($sformatf("withdraw c%0d if_rvalid", j), 32'(if_rvalid), 0);
    end
    @(negedge clk);
    drive(F, Z, F, F, Z, Z);
    #1;
    chk("withdraw final if_rvalid", 32'(if_rvalid), 1);
    chk("withdraw final if_rdata", if_rdata, 32'h0050_0093);
    @(negedge clk);
    drive(F, Z, T, F, B + 32'h4, Z);
    #1 chk("midreset d_gnt", 32'(d_gnt), 1);
    @(negedge clk);
    drive(T, B, T, F, B + 32'h4, Z);
    rst_n = 1'b0;
    #1 idle_chk_reset("midreset in");
    @(negedge clk);
    #1 idle_chk_reset("midreset hold");
    @(negedge clk);
    drive(F, Z, F, F, Z, Z);
    rst_n = 1'b1;
    #1 chk("midreset release d_rvalid", 32'(d_rvalid), 0);
    @(negedge clk);
    #1;
    chk("midreset after d_rvalid", 32'(d_rvalid), 0);
    chk("midreset after if_rvalid", 32'(if_rvalid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
